cache_rr_mux: RTL and testbench

Parametrised N-to-1 registered multiplexer with arbitration and valid/ready handshakes, generalising the cache's fixed 3-bit 2:1 select mux. It merges N requesting channels (e.g. refill, write-back, and hit-return paths) onto one downstream port. It selects a winner by fixed priority or round-robin and holds the result in an output register with backpressure. Output also reports which channel was forwarded.

---
 rtl/cache_pkg.sv | 8 +
 rtl/cache_rr_mux_if.sv | 16 +
 rtl/cache_rr_arb.sv | 44 ++++
 rtl/cache_rr_mux.sv | 52 +++++
 tb/tb_cache_rr_mux.sv | 120 ++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared mode encoding and index-width helper for the cache mux blocks.
package cache_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/cache_rr_mux_if.sv
// cache_rr_mux_if: N request channels in, one registered channel out, valid/ready on both sides.
interface cache_rr_mux_if import cache_pkg::*; #(
    parameter int WIDTH = 3,
    parameter int N_IN  = 2,
    parameter int SEL_W = idx_w(N_IN)
);
    logic [N_IN-1:0]       in_valid;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [N_IN-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_ready;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_sel);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sel);
endinterface

// File: rtl/cache_rr_arb.sv
// cache_rr_arb: fixed-priority / round-robin arbiter; pointer moves past the winner on each accept.
module cache_rr_arb import cache_pkg::*; #(
    parameter int N_IN  = 2,
    parameter int SEL_W = idx_w(N_IN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  req,
    input  logic             mode,
    input  logic             advance,
    output logic [N_IN-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d, base, idx;
    logic [SEL_W:0]   sum;
    logic             found;
    // Fixed mode is just a rotating search that always starts at channel 0.
    always_comb begin
        base      = (mode == MODE_RR) ? rr_ptr_q : '0;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N_IN; k++) begin
            sum = {1'b0, base} + (SEL_W+1)'(k);
            idx = (sum >= (SEL_W+1)'(N_IN)) ? SEL_W'(sum - (SEL_W+1)'(N_IN)) : SEL_W'(sum);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance && mode == MODE_RR)
            rr_ptr_d = (grant_idx == SEL_W'(N_IN-1)) ? '0 : grant_idx + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: rtl/cache_rr_mux.sv
// cache_rr_mux: N-to-1 arbitrated mux with a one-deep registered output under backpressure.
module cache_rr_mux import cache_pkg::*; #(
    parameter int WIDTH = 3,
    parameter int N_IN  = 2
) (
    input logic           clk,
    input logic           reset,
    input logic           mode,
    cache_rr_mux_if.slave bus
);
    localparam int SEL_W = idx_w(N_IN);
    logic [N_IN-1:0]  grant;
    logic [SEL_W-1:0] grant_idx, out_sel_q, out_sel_d;
    logic [WIDTH-1:0] mux_data, out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d, can_load, advance;
    cache_rr_arb #(.N_IN(N_IN), .SEL_W(SEL_W)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (bus.in_valid),
        .mode      (mode),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );
    assign can_load     = !out_valid_q || bus.out_ready;
    assign advance      = (|grant) && can_load && !reset;
    assign bus.in_ready = reset ? '0 : grant & {N_IN{can_load}};
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N_IN; i++)
            mux_data = mux_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
    always_comb begin
        out_valid_d = advance ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
        out_data_d  = advance ? mux_data : out_data_q;
        out_sel_d   = advance ? grant_idx : out_sel_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_cache_rr_mux.sv
// tb_cache_rr_mux: two instances (2x3-bit, 4x8-bit) run directed then random traffic against a queue-level model.
module tb_cache_rr_mux;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0] iv [2];
    logic [7:0] id [2][4];
    logic       md [2];
    logic       ordy [2];
    int         nin [2] = '{2, 4};
    int         wmask [2] = '{7, 255};
    int         m_valid [2], m_data [2], m_sel [2], m_ptr [2];
    int         vectors = 0, miscompares = 0;

    cache_rr_mux_if #(.WIDTH(3), .N_IN(2)) bus2 ();
    cache_rr_mux_if #(.WIDTH(8), .N_IN(4)) bus4 ();
    assign bus2.in_valid  = iv[0][1:0];
    assign bus2.in_data   = {id[0][1][2:0], id[0][0][2:0]};
    assign bus2.out_ready = ordy[0];
    assign bus4.in_valid  = iv[1];
    assign bus4.in_data   = {id[1][3], id[1][2], id[1][1], id[1][0]};
    assign bus4.out_ready = ordy[1];

    cache_rr_mux #(.WIDTH(3), .N_IN(2)) dut2 (.clk(clk), .reset(reset), .mode(md[0]), .bus(bus2.slave));
    cache_rr_mux #(.WIDTH(8), .N_IN(4)) dut4 (.clk(clk), .reset(reset), .mode(md[1]), .bus(bus4.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int n, input int s);
        for (int k = 0; k < n; k++)
            if (v[(s + k) % n]) return (s + k) % n;
        return -1;
    endfunction

    // Compare both DUTs to the model mid-cycle, then advance the model to the coming edge.
    task automatic cycle();
        int g, can, rdy;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            g   = reset ? -1 : pick(iv[u], nin[u], md[u] ? m_ptr[u] : 0);
            can = (!m_valid[u] || ordy[u]) ? 1 : 0;
            rdy = (g >= 0 && can != 0) ? (1 << g) : 0;
            check(u ? "out_valid4" : "out_valid2", u ? 32'(bus4.out_valid) : 32'(bus2.out_valid), 32'(m_valid[u]));
            check(u ? "out_data4"  : "out_data2",  u ? 32'(bus4.out_data)  : 32'(bus2.out_data),  32'(m_data[u]));
            check(u ? "out_sel4"   : "out_sel2",   u ? 32'(bus4.out_sel)   : 32'(bus2.out_sel),   32'(m_sel[u]));
            check(u ? "in_ready4"  : "in_ready2",  u ? 32'(bus4.in_ready)  : 32'(bus2.in_ready),  32'(rdy));
            if (reset) begin
                m_valid[u] = 0; m_data[u] = 0; m_sel[u] = 0; m_ptr[u] = 0;
            end else if (rdy != 0) begin
                m_valid[u] = 1;
                m_data[u]  = int'(id[u][g]) & wmask[u];
                m_sel[u]   = g;
                if (md[u]) m_ptr[u] = (g + 1) % nin[u];
            end else if (ordy[u]) begin
                m_valid[u] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            iv[u] = '0; md[u] = 1'b0; ordy[u] = 1'b1;
            m_valid[u] = 0; m_data[u] = 0; m_sel[u] = 0; m_ptr[u] = 0;
            for (int c = 0; c < 4; c++) id[u][c] = 8'(c);
        end
        repeat (2) cycle();
        reset = 1'b0;
        repeat (10) cycle();
        // Fixed priority on the 2-channel instance: channel 1 starves.
        iv[0] = 4'b0011; id[0][0] = 8'h5; id[0][1] = 8'h2;
        repeat (6) cycle();
        check("fixed_starve_sel", 32'(bus2.out_sel), 32'd0);
        check("fixed_starve_data", 32'(bus2.out_data), 32'd5);
        // Round-robin on the 4-channel instance.
        md[1] = 1'b1; iv[1] = 4'hF;
        for (int c = 0; c < 4; c++) id[1][c] = 8'h10 + 8'(c);
        repeat (5) cycle();
        // Backpressure: load A5 from ch2, stall 5 cycles, release.
        iv[1] = 4'b0100; id[1][2] = 8'hA5;
        cycle();
        iv[1] = 4'hF; ordy[1] = 1'b0;
        repeat (5) cycle();
        check("stall_hold_data", 32'(bus4.out_data), 32'hA5);
        ordy[1] = 1'b1;
        repeat (2) cycle();
        // Single requester after wrap, then reset mid-stall.
        iv[1] = 4'b0100; cycle();
        iv[1] = 4'b0010; cycle();
        ordy[1] = 1'b0; iv[1] = 4'hF; cycle();
        reset = 1'b1; cycle();
        reset = 1'b0; ordy[1] = 1'b1; cycle();
        // Mode switching with pointer retained.
        iv[1] = 4'b0010; cycle();
        iv[1] = 4'hF; md[1] = 1'b0; repeat (2) cycle();
        md[1] = 1'b1; repeat (3) cycle();
        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int u = 0; u < 2; u++) begin
                iv[u]   = 4'($urandom);
                ordy[u] = ($urandom_range(3) != 0);
                if ($urandom_range(15) == 0) md[u] = ~md[u];
                for (int c = 0; c < 4; c++) id[u][c] = 8'($urandom);
            end
            reset = ($urandom_range(63) == 0);
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
